// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, sequencer state encoding, default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;
  localparam logic [2:0] ALU_UGT = 3'b110;
  localparam logic [2:0] ALU_SGT = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // Two's-complement overflow of c = a +/- b, judged from the sign bits alone.
  function automatic logic signed_ovf(input logic is_sub, input logic a_msb,
                                      input logic b_msb, input logic c_msb);
    return ((a_msb ^ b_msb) == is_sub) & (c_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/alu_accum_seq.sv
// Accumulating sequencer in front of the combinational ALU: one reduced result per packet.
// Optional sticky signed-overflow flag (out_ovf) when ACC_OVF_DET_EN is defined.
//
// state    | meaning
// ST_IDLE  | no packet open; next beat starts one regardless of in_first
// ST_ACCUM | packet open; beats chain acc = acc OP in_data via the external ALU
// ST_RESP  | result presented on out_*; input stalled until out_ready
module alu_accum_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic             in_first,
  input  logic             in_last,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef ACC_OVF_DET_EN
  output logic             out_ovf,
`endif
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             beat;
  logic             restart;
  logic             chain;

  assign in_ready  = (state != ST_RESP);
  assign out_valid = (state == ST_RESP);
  assign out_data  = acc;
  assign out_count = count;

  assign alu_a  = acc;
  assign alu_b  = in_data;
  assign alu_op = in_op;

  assign beat    = in_valid & in_ready;
  // A first beat inside an open packet abandons it and starts over.
  assign restart = beat & ((state == ST_IDLE) | in_first);
  assign chain   = beat & (state == ST_ACCUM) & ~in_first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      count <= '0;
    end else if (restart) begin
      acc   <= in_data;
      count <= CNT_ONE;
      state <= in_last ? ST_RESP : ST_ACCUM;
    end else if (chain) begin
      acc <= alu_c;
      if (count != CNT_MAX) count <= count + CNT_ONE;
      state <= in_last ? ST_RESP : ST_ACCUM;
    end else if ((state == ST_RESP) && out_ready) begin
      state <= ST_IDLE;
    end
  end

`ifdef ACC_OVF_DET_EN
  logic ovf;
  logic ovf_hit;

  assign ovf_hit = ((in_op == ALU_ADD) | (in_op == ALU_SUB)) &
                   signed_ovf(in_op[0], acc[WIDTH-1], in_data[WIDTH-1], alu_c[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (restart) ovf <= 1'b0;
    else if (chain)   ovf <= ovf | ovf_hit;
  end

  assign out_ovf = ovf;
`endif

endmodule

// File: tb/tb_alu_accum_seq.sv
// Bench for alu_accum_seq: behavioural ALU beside the DUT, directed table, corner sequences,
// and randomized packets against a packet-level reference model.
module tb_alu_accum_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_first, in_last, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_data, alu_a, alu_b, alu_c, out_data;
  logic [2:0]  in_op, alu_op;
  logic [7:0]  out_count;
`ifdef ACC_OVF_DET_EN
  logic        out_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SRL: return (b >= 32) ? 32'd0 : (a >> b[4:0]);
      ALU_SRA: return (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
      ALU_UGT: return (a > b) ? 32'd1 : 32'd0;
      default: return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic ovf_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint r;
    if (op == ALU_ADD)      r = longint'($signed(a)) + longint'($signed(b));
    else if (op == ALU_SUB) r = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  assign alu_c = alu_f(alu_op, alu_a, alu_b);

  alu_accum_seq #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
    .in_first(in_first), .in_last(in_last),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef ACC_OVF_DET_EN
    .out_ovf(out_ovf),
`endif
    .out_count(out_count)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  op;
    logic        first;
    logic        last;
    logic [31:0] exp_data;
    logic [7:0]  exp_count;
    logic        exp_ovf;
  } beat_vec_t;

  beat_vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic send(input logic [31:0] d, input logic [2:0] op, input logic f, input logic l);
    int k;
    k = 0;
    in_valid = 1'b1; in_data = d; in_op = op; in_first = f; in_last = l;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the last beat was accepted: result must already be valid.
  task automatic expect_resp(input string name, input logic [31:0] ed, input logic [7:0] ec,
                             input logic eo, input int hold);
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_data"},  out_data, ed);
    check({name, "_count"}, {24'd0, out_count}, {24'd0, ec});
`ifdef ACC_OVF_DET_EN
    check({name, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
`endif
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    if (hold > 0) check({name, "_held"}, out_data, ed);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_done"}, {31'd0, out_valid}, 32'd0);
  endtask

  function automatic beat_vec_t mk(input logic [31:0] d, input logic [2:0] op, input logic f,
                                   input logic l, input logic [31:0] ed, input logic [7:0] ec);
    beat_vec_t v;
    v.data = d; v.op = op; v.first = f; v.last = l;
    v.exp_data = ed; v.exp_count = ec; v.exp_ovf = 1'b0;
    return v;
  endfunction

  initial begin
    logic [31:0] pd[16];
    logic [2:0]  po[16];
    logic        pf[16];
    logic [31:0] m_acc;
    int          m_cnt;
    logic        m_ovf;
    int          nb;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0;
    in_first = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    check("rst_out_count", {24'd0, out_count}, 32'd0);
`ifdef ACC_OVF_DET_EN
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tbl.push_back(mk(32'd5,        ALU_ADD, 1, 0, 0, 0));
    tbl.push_back(mk(32'd3,        ALU_ADD, 0, 0, 0, 0));
    tbl.push_back(mk(32'd1,        ALU_SUB, 0, 1, 32'd7, 8'd3));
    tbl.push_back(mk(32'hDEADBEEF, ALU_ADD, 1, 1, 32'hDEADBEEF, 8'd1));
    tbl.push_back(mk(32'h10,       ALU_ADD, 1, 0, 0, 0));
    tbl.push_back(mk(32'h01,       ALU_OR,  0, 0, 0, 0));
    tbl.push_back(mk(32'h80,       ALU_ADD, 1, 0, 0, 0));
    tbl.push_back(mk(32'd4,        ALU_SRA, 0, 1, 32'h8, 8'd2));
    tbl.push_back(mk(32'hF0F0,     ALU_ADD, 1, 0, 0, 0));
    tbl.push_back(mk(32'h0FF0,     ALU_AND, 0, 1, 32'h00F0, 8'd2));
    tbl.push_back(mk(32'h80000000, ALU_ADD, 1, 0, 0, 0));
    tbl.push_back(mk(32'd31,       ALU_SRL, 0, 1, 32'd1, 8'd2));
    tbl.push_back(mk(32'd5,        ALU_ADD, 1, 0, 0, 0));
    tbl.push_back(mk(32'd3,        ALU_UGT, 0, 1, 32'd1, 8'd2));
    tbl.push_back(mk(32'hFFFFFFFF, ALU_ADD, 1, 0, 0, 0));
    tbl.push_back(mk(32'd0,        ALU_SGT, 0, 1, 32'd0, 8'd2));
    tbl.push_back(mk(32'd3,        ALU_ADD, 1, 0, 0, 0));
    tbl.push_back(mk(32'd40,       ALU_SRL, 0, 1, 32'd0, 8'd2));
    tbl.push_back(mk(32'h80000000, ALU_ADD, 1, 0, 0, 0));
    tbl.push_back(mk(32'd40,       ALU_SRA, 0, 1, 32'hFFFFFFFF, 8'd2));
    tbl.push_back(mk(32'd9,        ALU_SUB, 0, 0, 0, 0));
    tbl.push_back(mk(32'd1,        ALU_ADD, 0, 1, 32'd10, 8'd2));

    foreach (tbl[i]) begin
      send(tbl[i].data, tbl[i].op, tbl[i].first, tbl[i].last);
      if (tbl[i].last)
        expect_resp($sformatf("tbl%0d", i), tbl[i].exp_data, tbl[i].exp_count, tbl[i].exp_ovf, 0);
    end

    // Result held under back-pressure; a beat offered in RESP must be refused.
    send(32'h1234, ALU_ADD, 1, 1);
    in_valid = 1'b1; in_data = 32'h5555; in_op = ALU_ADD; in_first = 1'b1; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_in_ready",  {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data",  out_data, 32'h1234);
      check("bp_out_count", {24'd0, out_count}, 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    expect_resp("bp", 32'h1234, 8'd1, 1'b0, 0);
    check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    check("bp_acc_kept",   out_data, 32'h1234);

    // Gaps between beats, then asynchronous reset mid-packet.
    send(32'h100, ALU_ADD, 1, 0);
    repeat (2) begin @(posedge clk); #1; end
    send(32'h5, ALU_ADD, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data",  out_data, 32'd0);
    check("arst_out_count", {24'd0, out_count}, 32'd0);
    check("arst_in_ready",  {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'd7, ALU_ADD, 0, 0);
    @(posedge clk); #1;
    send(32'd2, ALU_SUB, 0, 1);
    expect_resp("post_rst", 32'd5, 8'd2, 1'b0, 0);

    // Beat counter saturates while the data keeps accumulating.
    send(32'd1, ALU_ADD, 1, 0);
    for (int i = 1; i < 300; i++) send(32'd1, ALU_ADD, 0, (i == 299));
    expect_resp("sat", 32'd300, 8'd255, 1'b0, 0);

    send(32'h7FFFFFFF, ALU_ADD, 1, 0);
    send(32'd1, ALU_ADD, 0, 1);
    expect_resp("ovf_add", 32'h80000000, 8'd2, 1'b1, 0);
    send(32'd1, ALU_ADD, 1, 0);
    send(32'd1, ALU_ADD, 0, 1);
    expect_resp("ovf_clr", 32'd2, 8'd2, 1'b0, 0);

    for (int p = 0; p < 150; p++) begin
      nb = $urandom_range(1, 8);
      for (int b = 0; b < nb; b++) begin
        case ($urandom_range(0, 3))
          0: pd[b] = 32'h7FFFFFF0 + $urandom_range(0, 31);
          1: pd[b] = 32'h80000000 + $urandom_range(0, 31);
          2: pd[b] = $urandom_range(0, 40);
          default: pd[b] = $urandom;
        endcase
        po[b] = 3'($urandom_range(0, 7));
        pf[b] = (b == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
      end
      m_acc = '0; m_cnt = 0; m_ovf = 1'b0;
      for (int b = 0; b < nb; b++) begin
        if (b == 0 || pf[b]) begin
          m_acc = pd[b]; m_cnt = 1; m_ovf = 1'b0;
        end else begin
          m_ovf = m_ovf | ovf_f(po[b], m_acc, pd[b]);
          m_acc = alu_f(po[b], m_acc, pd[b]);
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
      end
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send(pd[b], po[b], pf[b], (b == nb - 1));
      end
      expect_resp($sformatf("rnd%0d", p), m_acc, 8'(m_cnt), m_ovf, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
